// File: rtl/i2c_req_arbiter_if.sv
// Requester handshake and I2C master command/monitor signals of the request arbiter.
// The master modport is the arbiter's view; slave is the requesters plus master core.
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            done;
    logic                          timeout_err;
    logic                          busy;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          start;
    logic                          stop;
    logic                          rw;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          i2c_scl;
    logic                          i2c_sda;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, i2c_scl, i2c_sda,
        output req_ready, done, timeout_err, busy, grant_id,
               start, stop, rw, addr, w_data
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, i2c_scl, i2c_sda,
        input  req_ready, done, timeout_err, busy, grant_id,
               start, stop, rw, addr, w_data
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master core between NUM_REQ single-byte requesters;
// completion is inferred from START/STOP conditions seen on the monitored bus lines.
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset,
    i2c_req_arbiter_if.master  bus
);
    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_START, WAIT_STOP} state_t;

    state_t                  state_reg;
    logic [ID_WIDTH-1:0]     ptr_reg;
    logic [ID_WIDTH-1:0]     grant_id_reg;
    logic [CNT_WIDTH-1:0]    cnt_reg;
    logic [NUM_REQ-1:0]      req_ready_reg;
    logic [NUM_REQ-1:0]      done_reg;
    logic                    timeout_err_reg;
    logic                    busy_reg;
    logic                    start_reg;
    logic                    stop_reg;
    logic                    rw_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;

    logic scl_meta_reg, scl_s_reg, scl_p_reg;
    logic sda_meta_reg, sda_s_reg, sda_p_reg;
    logic start_evt, stop_evt;

    logic [ADDR_WIDTH-1:0]   slot_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   slot_wdata [NUM_REQ];
    logic [ID_WIDTH-1:0]     grant_next;
    logic                    grant_found;
    logic [ID_WIDTH-1:0]     ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_addr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign slot_wdata[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan downward so the lowest rotated offset from ptr_reg is the last (winning) write.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        grant_next  = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(ptr_reg) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                grant_next  = idx;
                grant_found = 1'b1;
            end
        end
    end

    assign ptr_next  = (grant_id_reg == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
    assign start_evt = scl_s_reg & scl_p_reg & ~sda_s_reg &  sda_p_reg;
    assign stop_evt  = scl_s_reg & scl_p_reg &  sda_s_reg & ~sda_p_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_id_reg    <= '0;
            cnt_reg         <= '0;
            req_ready_reg   <= '0;
            done_reg        <= '0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
            start_reg       <= 1'b0;
            stop_reg        <= 1'b0;
            rw_reg          <= 1'b0;
            addr_reg        <= '0;
            w_data_reg      <= '0;
            scl_meta_reg    <= 1'b1;
            scl_s_reg       <= 1'b1;
            scl_p_reg       <= 1'b1;
            sda_meta_reg    <= 1'b1;
            sda_s_reg       <= 1'b1;
            sda_p_reg       <= 1'b1;
        end else begin
            scl_meta_reg    <= bus.i2c_scl;
            scl_s_reg       <= scl_meta_reg;
            scl_p_reg       <= scl_s_reg;
            sda_meta_reg    <= bus.i2c_sda;
            sda_s_reg       <= sda_meta_reg;
            sda_p_reg       <= sda_s_reg;
            req_ready_reg   <= '0;
            done_reg        <= '0;
            timeout_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        state_reg     <= CMD;
                        grant_id_reg  <= grant_next;
                        addr_reg      <= slot_addr[grant_next];
                        w_data_reg    <= slot_wdata[grant_next];
                        rw_reg        <= bus.req_rw[grant_next];
                        req_ready_reg <= NUM_REQ'(1) << grant_next;
                        start_reg     <= 1'b1;
                        stop_reg      <= 1'b1;
                        busy_reg      <= 1'b1;
                        cnt_reg       <= '0;
                    end
                end
                CMD: begin
                    state_reg <= WAIT_START;
                    start_reg <= 1'b0;
                    cnt_reg   <= '0;
                end
                WAIT_START: begin
                    if (cnt_reg == CNT_WIDTH'(TIMEOUT_CYC - 1)) begin
                        state_reg       <= IDLE;
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        stop_reg        <= 1'b0;
                        ptr_reg         <= ptr_next;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                        if (start_evt) begin
                            state_reg <= WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    // A completing STOP takes priority over an expiring timeout.
                    if (stop_evt) begin
                        state_reg <= IDLE;
                        done_reg  <= NUM_REQ'(1) << grant_id_reg;
                        busy_reg  <= 1'b0;
                        stop_reg  <= 1'b0;
                        ptr_reg   <= ptr_next;
                    end else if (cnt_reg == CNT_WIDTH'(TIMEOUT_CYC - 1)) begin
                        state_reg       <= IDLE;
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        stop_reg        <= 1'b0;
                        ptr_reg         <= ptr_next;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.done        = done_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.busy        = busy_reg;
    assign bus.grant_id    = grant_id_reg;
    assign bus.start       = start_reg;
    assign bus.stop        = stop_reg;
    assign bus.rw          = rw_reg;
    assign bus.addr        = addr_reg;
    assign bus.w_data      = w_data_reg;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus randomized requests checked
// against a round-robin reference model and a simple I2C bus driver.
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    i2c_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] slot_addr  [N];
    logic [DW-1:0] slot_wdata [N];
    logic [N-1:0]  valid_m;
    logic [N-1:0]  rw_m;
    int            ptr_m;
    int            last_g;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus_if.req_valid = valid_m;
        bus_if.req_rw    = rw_m;
        for (int i = 0; i < N; i++) begin
            bus_if.req_addr[i*AW +: AW]  = slot_addr[i];
            bus_if.req_wdata[i*DW +: DW] = slot_wdata[i];
        end
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < N; i++) begin
            slot_addr[i]  = AW'($urandom);
            slot_wdata[i] = DW'($urandom);
        end
        rw_m = N'($urandom);
    endtask

    // Reference: first pending requester at or after the pointer, wrapping around.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (valid_m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    // Called in an IDLE cycle with requests already applied; returns in the IDLE
    // cycle that shows done or timeout_err.
    task automatic run_txn(input bit do_timeout, input logic [N-1:0] next_valid);
        int g;
        logic [N-1:0] oh;
        g = pick();
        if (g < 0) begin
            errors++;
            $display("FAIL run_txn no pending request observed=0 required=nonzero");
            return;
        end
        oh = N'(1) << g;
        tick();
        chk("cmd_req_ready", 32'(bus_if.req_ready), 32'(oh));
        chk("cmd_start",     32'(bus_if.start), 1);
        chk("cmd_stop",      32'(bus_if.stop), 1);
        chk("cmd_busy",      32'(bus_if.busy), 1);
        chk("cmd_grant_id",  32'(bus_if.grant_id), 32'(g));
        chk("cmd_addr",      32'(bus_if.addr), 32'(slot_addr[g]));
        chk("cmd_w_data",    32'(bus_if.w_data), 32'(slot_wdata[g]));
        chk("cmd_rw",        32'(bus_if.rw), 32'(rw_m[g]));
        valid_m = next_valid;
        drive();
        tick();
        chk("ws_start",     32'(bus_if.start), 0);
        chk("ws_req_ready", 32'(bus_if.req_ready), 0);
        chk("ws_stop",      32'(bus_if.stop), 1);
        chk("ws_addr_hold", 32'(bus_if.addr), 32'(slot_addr[g]));
        if (do_timeout) begin
            repeat (TO - 1) tick();
            chk("to_pre_err",  32'(bus_if.timeout_err), 0);
            chk("to_pre_busy", 32'(bus_if.busy), 1);
            tick();
            chk("to_err",  32'(bus_if.timeout_err), 1);
            chk("to_done", 32'(bus_if.done), 0);
            chk("to_busy", 32'(bus_if.busy), 0);
            chk("to_stop", 32'(bus_if.stop), 0);
        end else begin
            bus_if.i2c_sda = 1'b0;
            repeat (3) tick();
            bus_if.i2c_scl = 1'b0;
            repeat (2) tick();
            bus_if.i2c_scl = 1'b1;
            repeat (3) tick();
            chk("wstop_busy", 32'(bus_if.busy), 1);
            bus_if.i2c_sda = 1'b1;
            repeat (2) tick();
            chk("stop_pre_done", 32'(bus_if.done), 0);
            tick();
            chk("done",         32'(bus_if.done), 32'(oh));
            chk("done_busy",    32'(bus_if.busy), 0);
            chk("done_stop",    32'(bus_if.stop), 0);
            chk("done_timeout", 32'(bus_if.timeout_err), 0);
            chk("done_addr",    32'(bus_if.addr), 32'(slot_addr[g]));
        end
        ptr_m  = (g + 1) % N;
        last_g = g;
    endtask

    initial begin
        int g_rst;
        bus_if.i2c_scl = 1'b1;
        bus_if.i2c_sda = 1'b1;
        valid_m = '0;
        rw_m    = '0;
        for (int i = 0; i < N; i++) begin
            slot_addr[i]  = '0;
            slot_wdata[i] = '0;
        end
        drive();
        ptr_m  = 0;
        last_g = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_outputs", {bus_if.req_ready, bus_if.done, bus_if.timeout_err, bus_if.busy,
                            bus_if.start, bus_if.stop, bus_if.rw, 7'(bus_if.grant_id)}, 0);
        chk("rst_addr",   32'(bus_if.addr), 0);
        chk("rst_w_data", 32'(bus_if.w_data), 0);
        reset = 1'b1;

        // Fairness with all four requesting
        randomize_slots();
        valid_m = 4'b1111;
        drive();
        for (int i = 0; i < 5; i++) run_txn(1'b0, 4'b1111);

        // Single request from slot 2
        randomize_slots();
        slot_addr[2]  = 7'h50;
        slot_wdata[2] = 8'hA5;
        rw_m[2]       = 1'b0;
        valid_m       = 4'b0100;
        drive();
        run_txn(1'b0, 4'b0000);

        // Pointer skip: grant 1, then 1010 -> 3 then 1
        valid_m = 4'b0010;
        drive();
        run_txn(1'b0, 4'b0000);
        valid_m = 4'b1010;
        drive();
        run_txn(1'b0, 4'b1010);
        run_txn(1'b0, 4'b0000);

        // Timeout with a pending request from the next index
        valid_m = 4'b0100;
        drive();
        run_txn(1'b1, 4'b1100);
        run_txn(1'b0, 4'b0000);

        // Reset during WAIT_STOP
        randomize_slots();
        valid_m = 4'b0100;
        drive();
        g_rst = pick();
        tick();
        chk("rstx_req_ready", 32'(bus_if.req_ready), 32'(N'(1) << g_rst));
        valid_m = '0;
        drive();
        tick();
        bus_if.i2c_sda = 1'b0;
        repeat (3) tick();
        chk("rstx_busy", 32'(bus_if.busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rstx_outputs", {bus_if.req_ready, bus_if.done, bus_if.timeout_err, bus_if.busy,
                             bus_if.start, bus_if.stop, bus_if.rw, 7'(bus_if.grant_id)}, 0);
        chk("rstx_addr",   32'(bus_if.addr), 0);
        chk("rstx_w_data", 32'(bus_if.w_data), 0);
        ptr_m  = 0;
        last_g = 0;
        repeat (3) tick();
        bus_if.i2c_sda = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstx_late_stop", {28'(bus_if.done), 3'(0), bus_if.busy}, 0);
        end
        valid_m = 4'b1111;
        drive();
        run_txn(1'b0, 4'b0000);

        // Spurious bus activity with nothing requested
        valid_m = '0;
        drive();
        for (int i = 0; i < 6; i++) begin
            bus_if.i2c_sda = (i >= 3);
            repeat (2) tick();
            chk("spur_quiet", {bus_if.req_ready, bus_if.done, bus_if.timeout_err,
                               bus_if.busy, bus_if.start, bus_if.stop}, 0);
            chk("spur_grant_id", 32'(bus_if.grant_id), 32'(last_g));
        end

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            randomize_slots();
            valid_m = N'($urandom_range(1, (1 << N) - 1));
            drive();
            run_txn($urandom_range(0, 5) == 0, N'($urandom));
        end

        valid_m = '0;
        drive();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one I2C master core between NUM_REQ requesters. Each requester posts a single-byte transaction: address, rw and write data.
- The block picks one requester by round-robin and drives the master command inputs (start, stop, rw, addr, w_data).
- It tracks the transfer by monitoring the master's i2c_scl/i2c_sda lines for START and STOP conditions, then reports per-requester completion or a timeout.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_WIDTH, 7, I2C slave address width
DATA_WIDTH, 8, write data width
TIMEOUT_CYC, 4096, max clk cycles spent waiting for bus START+STOP per transaction

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester transaction request, level
req_rw  in  NUM_REQ  per-requester rw bit
req_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-cycle acceptance pulse, one-hot
done  out  NUM_REQ  one-cycle completion pulse, one-hot
timeout_err  out  1  one-cycle pulse, granted transaction timed out
busy  out  1  transaction in flight
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
start  out  1  to master: start command
stop  out  1  to master: stop after byte
rw  out  1  to master
addr  out  ADDR_WIDTH  to master
w_data  out  DATA_WIDTH  to master
i2c_scl  in  1  monitored master SCL
i2c_sda  in  1  monitored master SDA

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0. Round-robin pointer = 0. FSM = IDLE. Timeout counter = 0. Sync/history flops = 1.
- Bus monitor:
  - 2-flop synchronizer on scl and sda gives scl_s and sda_s; one more flop gives scl_p and sda_p.
  - START event = scl_s & scl_p & ~sda_s & sda_p.
  - STOP event = scl_s & scl_p & sda_s & ~sda_p.
- FSM states: IDLE, CMD, WAIT_START, WAIT_STOP.
- IDLE:
  - If |req_valid, grant g = first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - At that edge, register addr/rw/w_data from slot g and set grant_id=g.
  - In the next cycle (state CMD): req_ready[g]=1, start=1, stop=1, busy=1.
  - Bus events in IDLE are ignored.
- CMD: lasts exactly one cycle, then WAIT_START. The timeout counter is cleared on entry.
- WAIT_START:
  - start=0; stop stays 1.
  - START event moves to WAIT_STOP.
  - STOP events are ignored.
- WAIT_STOP:
  - STOP event moves to IDLE.
  - done[g]=1 in the cycle after the STOP event is detected.
  - ptr = (g+1) mod NUM_REQ.
  - stop, start, busy return to 0.
- Timeout:
  - The counter increments each cycle in WAIT_START/WAIT_STOP.
  - If it reaches TIMEOUT_CYC-1 without a completing STOP, go to IDLE.
  - timeout_err=1 one cycle, done stays 0, ptr = (g+1) mod NUM_REQ.
  - If a STOP event and timeout occur in the same cycle, STOP wins (done, no timeout_err).
- addr/rw/w_data/grant_id hold stable from CMD until the next grant. They are not cleared on completion.
- req_valid deasserted before grant: no grant. req_valid deasserted after req_ready: no effect.
- A new grant may occur in the cycle IDLE is re-entered (back-to-back).
- Reset mid-transaction: next cycle all outputs 0, FSM IDLE, ptr 0. A later bus STOP produces no done.
- Throughput: at most one transaction in flight. req_ready and done each pulse exactly once per completed transaction.

Test Plan:
1. Single request: req_valid=4'b0100, addr slot2=7'h50, rw=0, wdata=8'hA5.
   -> Next cycle: req_ready=4'b0100, start=1 for 1 cycle, stop=1, addr=7'h50, w_data=8'hA5, grant_id=2.
   -> Bus model START then STOP: done=4'b0100 one cycle after STOP detection, busy=0.
2. Fairness: req_valid=4'b1111 held, each transfer completed by bus model.
   -> Grant order 0,1,2,3,0; grant_id matches each req_ready pulse.
3. Pointer skip: last grant was 1, then req_valid=4'b1010.
   -> Next grant 3, then 1.
4. Timeout: TIMEOUT_CYC=64, bus idle (scl=sda=1) after CMD.
   -> timeout_err pulses after 64 wait cycles, done=0, busy=0.
   -> Pending request from next index is granted immediately.
5. Reset mid-transfer: assert reset low 1 cycle during WAIT_STOP.
   -> All outputs 0 next cycle.
   -> Subsequent bus STOP gives done=0; next grant starts from requester 0.
6. Spurious bus activity: START/STOP on bus with req_valid=0.
   -> No change on any output, busy stays 0.
